// File: rtl/icache_refill_ctrl_if.sv
// Bus bundle for the L1 instruction-cache refill engine.
//   master : the refill controller view (fetch miss in, lower-memory request/response, cache write out)
//   slave  : the surrounding fetch stage / memory / cache view
// Signals:
//   miss_i, missAddr_i, flush_i                 fetch-stage miss and redirect
//   memReq_o, memReqAddr_o, memReqAck_i         line request handshake to lower memory
//   memRespValid_i, memRespData_i               response beats, beat 0 first
//   wrEnable_o, wrAddr_o, instBlock_o           cache line write port
//   busy_o                                      refill in progress (fetch stall)
interface icache_refill_ctrl_if #(
  parameter int unsigned SIZE_PC     = 32,
  parameter int unsigned CACHE_WIDTH = 256,
  parameter int unsigned MEM_WIDTH   = 64
);
  logic                   miss_i;
  logic [SIZE_PC-1:0]     missAddr_i;
  logic                   flush_i;
  logic                   memReq_o;
  logic [SIZE_PC-1:0]     memReqAddr_o;
  logic                   memReqAck_i;
  logic                   memRespValid_i;
  logic [MEM_WIDTH-1:0]   memRespData_i;
  logic                   wrEnable_o;
  logic [SIZE_PC-1:0]     wrAddr_o;
  logic [CACHE_WIDTH-1:0] instBlock_o;
  logic                   busy_o;

  modport master (
    input  miss_i, missAddr_i, flush_i, memReqAck_i, memRespValid_i, memRespData_i,
    output memReq_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );

  modport slave (
    output miss_i, missAddr_i, flush_i, memReqAck_i, memRespValid_i, memRespData_i,
    input  memReq_o, memReqAddr_o, wrEnable_o, wrAddr_o, instBlock_o, busy_o
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// L1 instruction-cache miss/refill engine.
// Captures the line-aligned miss address, requests the line from lower memory,
// assembles MEM_WIDTH-bit beats into a CACHE_WIDTH-bit line and writes it into
// the cache with a single-cycle strobe. A fetch redirect abandons the refill;
// beats already promised by memory are drained without writing.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    icache_refill_ctrl_if.master (miss/flush in, memory request/response,
//          cache write port, busy)
module icache_refill_ctrl #(
  parameter int unsigned SIZE_PC     = 32,
  parameter int unsigned CACHE_WIDTH = 256,
  parameter int unsigned MEM_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  icache_refill_ctrl_if.master bus
);

  localparam int unsigned BEATS = CACHE_WIDTH / MEM_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [SIZE_PC-1:0] OFF_MASK  = SIZE_PC'(CACHE_WIDTH / 8 - 1);

  typedef enum logic [2:0] {IDLE, REQ, FILL, DRAIN, WRITE, HOLD} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       beatCnt;
  logic [CACHE_WIDTH-1:0] lineBuf;
  logic [SIZE_PC-1:0]     addrReg;

  logic [SIZE_PC-1:0]     lineAddr;
  logic [CACHE_WIDTH-1:0] lineNext;
  logic                   lastBeat;

  always_comb begin
    lineAddr = bus.missAddr_i & ~OFF_MASK;
    lastBeat = (beatCnt == LAST_BEAT);
  end

  // Buffer with the current beat merged in; lets the last beat go straight to
  // instBlock_o so the write strobe appears one cycle after it.
  always_comb begin
    lineNext = lineBuf;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (beatCnt == CNT_W'(b)) begin
        lineNext[b*MEM_WIDTH +: MEM_WIDTH] = bus.memRespData_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      beatCnt          <= '0;
      lineBuf          <= '0;
      addrReg          <= '0;
      bus.memReq_o     <= 1'b0;
      bus.memReqAddr_o <= '0;
      bus.wrEnable_o   <= 1'b0;
      bus.wrAddr_o     <= '0;
      bus.instBlock_o  <= '0;
      bus.busy_o       <= 1'b0;
    end else begin
      bus.wrEnable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.miss_i && !bus.flush_i) begin
            addrReg          <= lineAddr;
            bus.memReqAddr_o <= lineAddr;
            bus.memReq_o     <= 1'b1;
            bus.busy_o       <= 1'b1;
            state            <= REQ;
          end
        end
        REQ: begin
          if (bus.memReqAck_i) begin
            // An accepted request still returns beats, so a same-cycle flush drains them.
            bus.memReq_o <= 1'b0;
            beatCnt      <= '0;
            state        <= bus.flush_i ? DRAIN : FILL;
          end else if (bus.flush_i) begin
            bus.memReq_o <= 1'b0;
            bus.busy_o   <= 1'b0;
            state        <= IDLE;
          end
        end
        FILL: begin
          if (bus.memRespValid_i) begin
            lineBuf <= lineNext;
            beatCnt <= beatCnt + CNT_W'(1);
          end
          if (bus.flush_i) begin
            if (bus.memRespValid_i && lastBeat) begin
              bus.busy_o <= 1'b0;
              state      <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (bus.memRespValid_i && lastBeat) begin
            bus.wrEnable_o  <= 1'b1;
            bus.wrAddr_o    <= addrReg;
            bus.instBlock_o <= lineNext;
            state           <= WRITE;
          end
        end
        DRAIN: begin
          if (bus.memRespValid_i) begin
            if (lastBeat) begin
              bus.busy_o <= 1'b0;
              state      <= IDLE;
            end else begin
              beatCnt <= beatCnt + CNT_W'(1);
            end
          end
        end
        WRITE: begin
          state <= HOLD;
        end
        HOLD: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.memReq_o <= 1'b0;
          bus.busy_o   <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
